// File: rtl/regfile_onehot_wr.sv
// 32 x DATA_W register file: one-hot write select, two combinational read ports, x0 = 0, sticky multi-hot flag, saturating write counter.
// Writes land on the clock edge and are readable the next cycle; REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_onehot_wr #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_wr_sel,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [4:0]        i_rs1_addr,
  input  logic [4:0]        i_rs2_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  input  logic              i_err_clr,
  output logic              o_onehot_err,
  output logic [15:0]       o_wr_count
);

  logic [DATA_W-1:0] regs [32];
  logic              multi_hot;
  logic              wr_any;

  // More than one bit set (bit 0 included): clearing the lowest set bit leaves something.
  assign multi_hot = (i_wr_sel & (i_wr_sel - 32'd1)) != 32'd0;
  assign wr_any    = |i_wr_sel[31:1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs[0] <= '0;
      for (int k = 1; k < 32; k++) begin
        regs[k] <= RESET_VAL;
      end
    end else begin
      regs[0] <= '0;
      for (int k = 1; k < 32; k++) begin
        if (i_wr_sel[k]) begin
          regs[k] <= i_wr_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_onehot_err <= 1'b0;
    end else if (multi_hot) begin
      o_onehot_err <= 1'b1;
    end else if (i_err_clr) begin
      o_onehot_err <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_count <= 16'd0;
    end else if (wr_any && (o_wr_count != 16'hFFFF)) begin
      o_wr_count <= o_wr_count + 16'd1;
    end
  end

  always_comb begin
    o_rs1_data = regs[i_rs1_addr];
    o_rs2_data = regs[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if ((i_rs1_addr != 5'd0) && i_wr_sel[i_rs1_addr]) begin
      o_rs1_data = i_wr_data;
    end
    if ((i_rs2_addr != 5'd0) && i_wr_sel[i_rs2_addr]) begin
      o_rs2_data = i_wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Scoreboard bench for regfile_onehot_wr: expectations queued when stimulus is driven, compared when outputs are sampled.
module tb_regfile_onehot_wr;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_wr_sel;
  logic [31:0] i_wr_data;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic        i_err_clr;
  logic        o_onehot_err;
  logic [15:0] o_wr_count;

  regfile_onehot_wr #(.DATA_W(32), .RESET_VAL(32'd0)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_wr_sel     (i_wr_sel),
    .i_wr_data    (i_wr_data),
    .i_rs1_addr   (i_rs1_addr),
    .i_rs2_addr   (i_rs2_addr),
    .o_rs1_data   (o_rs1_data),
    .o_rs2_data   (o_rs2_data),
    .i_err_clr    (i_err_clr),
    .o_onehot_err (o_onehot_err),
    .o_wr_count   (o_wr_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam int K_RS1 = 0, K_RS2 = 1, K_ERR = 2, K_CNT = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq [$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] m_regs [32];
  logic        m_err;
  logic [15:0] m_cnt;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_RS1:   obs = o_rs1_data;
        K_RS2:   obs = o_rs2_data;
        K_ERR:   obs = {31'd0, o_onehot_err};
        default: obs = {16'd0, o_wr_count};
      endcase
      check_val(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [31:0] sel, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && sel[a]) return d;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    m_err = 1'b0;
    m_cnt = 16'd0;
  endtask

  // Called just after a rising edge; drives one cycle, checks at the falling edge, advances the model.
  task automatic cycle(input logic [31:0] sel, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2, input logic clr);
    i_wr_sel   = sel;
    i_wr_data  = d;
    i_rs1_addr = a1;
    i_rs2_addr = a2;
    i_err_clr  = clr;
    push("rs1_model", K_RS1, exp_rd(a1, sel, d));
    push("rs2_model", K_RS2, exp_rd(a2, sel, d));
    push("err_model", K_ERR, {31'd0, m_err});
    push("cnt_model", K_CNT, {16'd0, m_cnt});
    @(negedge i_clk);
    check_now();
    @(posedge i_clk);
    #1;
    for (int k = 1; k < 32; k++) if (sel[k]) m_regs[k] = d;
    if ($countones(sel) > 1) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if ((sel[31:1] != 31'd0) && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
  endtask

  initial begin
    logic [31:0] rsel;
    i_rst_n    = 1'b0;
    i_wr_sel   = '0;
    i_wr_data  = '0;
    i_rs1_addr = 5'd0;
    i_rs2_addr = 5'd31;
    i_err_clr  = 1'b0;
    model_reset();
    #1;
    push("rst_rs1_x0", K_RS1, 32'd0);
    push("rst_rs2_x31", K_RS2, 32'd0);
    push("rst_err", K_ERR, 32'd0);
    push("rst_cnt", K_CNT, 32'd0);
    check_now();
    @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic write then read on both ports.
    cycle(32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b0);
    push("wr_rs1_x5", K_RS1, 32'hDEAD_BEEF);
    push("wr_rs2_x5", K_RS2, 32'hDEAD_BEEF);
    push("wr_cnt1", K_CNT, 32'd1);
    cycle(32'd0, 32'd0, 5'd5, 5'd5, 1'b0);

    // x0 write is dropped and not counted.
    cycle(32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd5, 1'b0);
    push("x0_read", K_RS1, 32'd0);
    push("x0_cnt", K_CNT, 32'd1);
    cycle(32'd0, 32'd0, 5'd0, 5'd5, 1'b0);

    // Multi-hot write, then clear.
    cycle(32'h8000_0004, 32'h1234_5678, 5'd2, 5'd31, 1'b0);
    push("mh_x2", K_RS1, 32'h1234_5678);
    push("mh_x31", K_RS2, 32'h1234_5678);
    push("mh_err", K_ERR, 32'd1);
    push("mh_cnt", K_CNT, 32'd2);
    cycle(32'd0, 32'd0, 5'd2, 5'd31, 1'b1);
    push("clr_err", K_ERR, 32'd0);
    cycle(32'd0, 32'd0, 5'd0, 5'd0, 1'b0);

    // Set beats clear in the same cycle.
    cycle(32'h0000_0006, 32'h0BAD_F00D, 5'd1, 5'd2, 1'b1);
    push("setwin_err", K_ERR, 32'd1);
    push("setwin_cnt", K_CNT, 32'd3);
    push("setwin_x1", K_RS1, 32'h0BAD_F00D);
    cycle(32'd0, 32'd0, 5'd1, 5'd2, 1'b1);

    // x0 plus x5 is still multi-hot; x5 written, x0 stays zero.
    cycle(32'h0000_0021, 32'hCAFE_0001, 5'd5, 5'd0, 1'b0);
    push("mh0_err", K_ERR, 32'd1);
    push("mh0_cnt", K_CNT, 32'd4);
    push("mh0_x5", K_RS1, 32'hCAFE_0001);
    push("mh0_x0", K_RS2, 32'd0);
    cycle(32'd0, 32'd0, 5'd5, 5'd0, 1'b1);

    // Read during write to x7.
    cycle(32'h0000_0080, 32'hAAAA_0000, 5'd7, 5'd7, 1'b0);
    push("rdw_same", K_RS1, BYPASS ? 32'h5555_1111 : 32'hAAAA_0000);
    cycle(32'h0000_0080, 32'h5555_1111, 5'd7, 5'd0, 1'b0);
    push("rdw_next", K_RS1, 32'h5555_1111);
    cycle(32'd0, 32'd0, 5'd7, 5'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rsel = ($urandom_range(0, 4) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
      cycle(rsel, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
    end

    // Mid-cycle reset with non-zero contents and the flag set.
    cycle(32'h0000_000C, 32'h0000_0077, 5'd2, 5'd3, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    push("mrst_x2", K_RS1, 32'd0);
    push("mrst_x3", K_RS2, 32'd0);
    push("mrst_err", K_ERR, 32'd0);
    push("mrst_cnt", K_CNT, 32'd0);
    check_now();
    i_wr_sel   = 32'h0000_0002;
    i_wr_data  = 32'h0000_0ABC;
    i_rs1_addr = 5'd1;
    @(posedge i_clk);
    #1;
    push("inrst_x1", K_RS1, 32'd0);
    push("inrst_cnt", K_CNT, 32'd0);
    check_now();
    i_wr_sel = 32'd0;
    @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    push("rel_x1", K_RS1, 32'd0);
    push("rel_cnt", K_CNT, 32'd0);
    check_now();

    // Saturation of the write counter.
    i_wr_sel = 32'h0000_0002;
    for (int i = 0; i < 65540; i++) begin
      i_wr_data = i;
      @(posedge i_clk);
    end
    #1;
    i_wr_sel   = 32'd0;
    i_rs1_addr = 5'd1;
    m_cnt      = 16'hFFFF;
    m_regs[1]  = 32'd65539;
    #1;
    push("sat_cnt", K_CNT, 32'h0000_FFFF);
    push("sat_x1", K_RS1, 32'd65539);
    check_now();
    @(posedge i_clk);
    #1;
    cycle(32'h0000_0002, 32'h0000_0005, 5'd1, 5'd1, 1'b0);
    push("sat_hold", K_CNT, 32'h0000_FFFF);
    cycle(32'd0, 32'd0, 5'd1, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- 32-entry general-purpose register file for the single-cycle core.
- Sits directly downstream of the 5-to-32 write-address decoder. It consumes the decoder's one-hot select vector as per-register write enables and serves two combinational read ports to the datapath.
- x0 is hardwired to zero.
- A sticky flag reports any malformed (non-one-hot) write select.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- RESET_VAL, 0, value loaded into registers x1..x31 on reset.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_wr_sel  input  32  one-hot write select from the decoder; bit k enables a write to xk. All-zero means no write.
- i_wr_data  input  DATA_W  write data.
- i_rs1_addr  input  5  read port 1 address.
- i_rs2_addr  input  5  read port 2 address.
- o_rs1_data  output  DATA_W  read port 1 data, combinational.
- o_rs2_data  output  DATA_W  read port 2 data, combinational.
- i_err_clr  input  1  synchronous clear of the sticky error flag.
- o_onehot_err  output  1  sticky: a multi-hot i_wr_sel was seen.
- o_wr_count  output  16  count of committed writes; saturates.

Behaviour:
- Reset, asynchronous on falling i_rst_n and held while low:
  - x1..x31 load RESET_VAL.
  - o_onehot_err = 0.
  - o_wr_count = 0.
  - Read outputs follow the reset register contents (0 for x0; RESET_VAL otherwise).
- Reset deasserted mid-cycle: no write occurs until the first rising i_clk edge with i_rst_n high.
- Write, rising edge:
  - For each k in 1..31 with i_wr_sel[k] = 1, xk <= i_wr_data.
  - i_wr_sel[0] is ignored; x0 always reads 0.
- Write latency: one cycle. Data written at edge N is visible on the read ports after edge N, in cycle N+1.
- Read:
  - o_rsN_data = register[i_rsN_addr]; purely combinational.
  - Address 0 returns 0.
  - Both ports may read the same address simultaneously.
- Multi-hot select (popcount(i_wr_sel) > 1):
  - Every selected register (excluding x0) is written with i_wr_data; no priority logic.
  - o_onehot_err sets to 1 at that edge and stays 1 until i_err_clr or reset.
  - If i_err_clr and a multi-hot select occur in the same cycle, set wins and o_onehot_err = 1.
- o_wr_count:
  - Increments by 1 on each edge where i_wr_sel[31:1] != 0. A multi-hot write counts once.
  - Saturates at 16'hFFFF; no wrap.
  - A write selecting only x0 does not count.
- Read-during-write to the same address without the bypass feature: the read port returns the old value in that cycle and the new value in the next cycle.
- No X propagation: all 32 select bits are used. Unknown addresses are not a concern for synthesis, but the bench checks only known values.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If i_wr_sel[i_rsN_addr] = 1 and i_rsN_addr != 0 in the current cycle, o_rsN_data = i_wr_data combinationally (write-through forwarding).
  - Address 0 still returns 0.
  - Register state update is unchanged.
- Undefined: no forwarding; read-during-write returns the pre-edge contents, as described above.

Test Plan:
- Reset:
  - Stimulus: assert i_rst_n = 0 mid-cycle with registers previously non-zero.
  - Response: all reads return 0 immediately (RESET_VAL = 0); o_onehot_err = 0; o_wr_count = 0.
- Write/read:
  - Stimulus: i_wr_sel = 32'h0000_0020, i_wr_data = 32'hDEAD_BEEF; next cycle read with i_rs1_addr = 5 and i_rs2_addr = 5.
  - Response: both ports read DEAD_BEEF; o_wr_count = 1.
- x0 protection:
  - Stimulus: i_wr_sel = 32'h0000_0001, i_wr_data = 32'hFFFF_FFFF.
  - Response: read of x0 = 0; o_wr_count unchanged.
- Multi-hot select:
  - Stimulus: i_wr_sel = 32'h8000_0004, i_wr_data = 32'h1234_5678.
  - Response: x2 and x31 both read 12345678; o_onehot_err = 1; o_wr_count +1.
  - Stimulus: i_err_clr pulse with no multi-hot select.
  - Response: flag returns to 0.
- Read-during-write:
  - Stimulus: x7 = 32'hAAAA_0000; in the same cycle i_wr_sel = 32'h80, i_wr_data = 32'h5555_1111, i_rs1_addr = 7.
  - Response without REGFILE_BYPASS_EN: o_rs1_data = AAAA_0000 in that cycle, 5555_1111 in the next.
  - Response with REGFILE_BYPASS_EN: 5555_1111 in both cycles.
- Counter saturation:
  - Stimulus: 65,540 consecutive writes to x1.
  - Response: o_wr_count holds at 16'hFFFF.
